regfile_write_arbiter: RTL and testbench

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

---
 rtl/regfile_write_arbiter.sv | 67 ++++++
 tb/tb_regfile_write_arbiter.sv | 128 ++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: clears registers 0..30 after reset, then arbitrates two
// write requesters onto a single registered register-file write port.
module regfile_write_arbiter #(
   parameter int DATA_W = 64
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              a_valid,
   input  logic [4:0]        a_addr,
   input  logic [DATA_W-1:0] a_data,
   output logic              a_ready,
   input  logic              b_valid,
   input  logic [4:0]        b_addr,
   input  logic [DATA_W-1:0] b_data,
   output logic              b_ready,
   output logic              wr_en,
   output logic [4:0]        wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic              init_done
);
   typedef enum logic {INIT, RUN} state_t;
   state_t              r_state, w_next;
   logic [4:0]          r_cnt;
   logic                r_ptr;
   logic                w_run, w_xfer, w_write;
   logic [4:0]          w_addr;
   logic [DATA_W-1:0]   w_data;
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= INIT;
      else r_state <= w_next;
   end
   always_comb begin
      w_next = r_state;
      if (r_state == INIT && r_cnt == 5'd30) w_next = RUN;
   end
   // r_ptr=0 gives A priority on a contested cycle, r_ptr=1 gives B priority
   assign w_run   = (r_state == RUN);
   assign a_ready = w_run & a_valid & (~b_valid | ~r_ptr);
   assign b_ready = w_run & b_valid & (~a_valid | r_ptr);
   assign w_xfer  = a_ready | b_ready;
   assign w_addr  = a_ready ? a_addr : b_addr;
   assign w_data  = a_ready ? a_data : b_data;
   assign w_write = w_xfer & (w_addr != 5'd31);
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_en     <= 1'b0;
         wr_addr   <= '0;
         wr_data   <= '0;
         init_done <= 1'b0;
         r_cnt     <= '0;
         r_ptr     <= 1'b0;
      end else if (!w_run) begin
         wr_en     <= 1'b1;
         wr_addr   <= r_cnt;
         wr_data   <= '0;
         r_cnt     <= r_cnt + 5'd1;
         init_done <= (w_next == RUN);
      end else begin
         wr_en <= w_write;
         if (w_write) begin
            wr_addr <= w_addr;
            wr_data <= w_data;
         end
         if (w_xfer) r_ptr <= a_ready;
      end
   end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: directed checks of the clear sweep, arbitration and reset.
module tb_regfile_write_arbiter;
   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        a_valid = 1'b0, b_valid = 1'b0;
   logic [4:0]  a_addr = '0, b_addr = '0;
   logic [63:0] a_data = '0, b_data = '0;
   logic        a_ready, b_ready, wr_en, init_done;
   logic [4:0]  wr_addr;
   logic [63:0] wr_data;
   int          n_assert = 0;
   int          n_fail = 0;

   regfile_write_arbiter #(.DATA_W(64)) dut (
      .clk(clk), .reset_n(reset_n),
      .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
      .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .init_done(init_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, " wr_en"}, 64'(wr_en), 64'd0);
      chk({tag, " wr_addr"}, 64'(wr_addr), 64'd0);
      chk({tag, " wr_data"}, wr_data, 64'd0);
      chk({tag, " init_done"}, 64'(init_done), 64'd0);
   endtask

   initial begin
      #3;
      chk_zero("reset");
      a_valid = 1'b1; a_addr = 5'd1; a_data = 64'hAAAA_0001;
      b_valid = 1'b1; b_addr = 5'd2; b_data = 64'hBBBB_0002;
      @(negedge clk);
      #2 reset_n = 1'b1;
      for (int i = 0; i <= 30; i++) begin
         step();
         chk($sformatf("sweep%0d wr_en", i), 64'(wr_en), 64'd1);
         chk($sformatf("sweep%0d wr_addr", i), 64'(wr_addr), 64'(i));
         chk($sformatf("sweep%0d wr_data", i), wr_data, 64'd0);
         chk($sformatf("sweep%0d init_done", i), 64'(init_done), 64'(i == 30));
         if (i < 30) begin
            chk($sformatf("sweep%0d a_ready", i), 64'(a_ready), 64'd0);
            chk($sformatf("sweep%0d b_ready", i), 64'(b_ready), 64'd0);
         end
      end
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("contest%0d a_ready", k), 64'(a_ready), 64'(k % 2 == 0));
         chk($sformatf("contest%0d b_ready", k), 64'(b_ready), 64'(k % 2 == 1));
         step();
         chk($sformatf("contest%0d wr_en", k), 64'(wr_en), 64'd1);
         chk($sformatf("contest%0d wr_addr", k), 64'(wr_addr), (k % 2 == 0) ? 64'd1 : 64'd2);
         chk($sformatf("contest%0d wr_data", k), wr_data, (k % 2 == 0) ? 64'hAAAA_0001 : 64'hBBBB_0002);
      end
      a_valid = 1'b0; b_valid = 1'b0;
      step();
      chk("idle wr_en", 64'(wr_en), 64'd0);
      chk("idle wr_addr hold", 64'(wr_addr), 64'd2);
      chk("idle wr_data hold", wr_data, 64'hBBBB_0002);
      chk("idle init_done", 64'(init_done), 64'd1);
      a_valid = 1'b1; a_addr = 5'd5; a_data = 64'h1234;
      b_addr = 5'd9; b_data = 64'hFFFF;
      #1;
      chk("loneA a_ready", 64'(a_ready), 64'd1);
      chk("loneA b_ready", 64'(b_ready), 64'd0);
      step();
      a_valid = 1'b0;
      chk("loneA wr_en", 64'(wr_en), 64'd1);
      chk("loneA wr_addr", 64'(wr_addr), 64'd5);
      chk("loneA wr_data", wr_data, 64'h1234);
      b_valid = 1'b1; b_addr = 5'd31; b_data = 64'hDEAD;
      #1;
      chk("zeroreg b_ready", 64'(b_ready), 64'd1);
      chk("zeroreg a_ready", 64'(a_ready), 64'd0);
      step();
      b_valid = 1'b0;
      chk("zeroreg wr_en", 64'(wr_en), 64'd0);
      chk("zeroreg wr_addr hold", 64'(wr_addr), 64'd5);
      chk("zeroreg wr_data hold", wr_data, 64'h1234);
      a_valid = 1'b1; a_addr = 5'd7; a_data = 64'h77;
      step();
      chk("loneA2 wr_addr", 64'(wr_addr), 64'd7);
      a_addr = 5'd1; a_data = 64'hAAAA_0001;
      b_valid = 1'b1; b_addr = 5'd2; b_data = 64'hBBBB_0002;
      #1;
      chk("ptrB a_ready", 64'(a_ready), 64'd0);
      chk("ptrB b_ready", 64'(b_ready), 64'd1);
      step();
      chk("ptrB wr_addr", 64'(wr_addr), 64'd2);
      chk("ptrB wr_data", wr_data, 64'hBBBB_0002);
      b_valid = 1'b0; a_addr = 5'd9;
      #1 reset_n = 1'b0;
      #1;
      chk_zero("runreset");
      chk("runreset a_ready", 64'(a_ready), 64'd0);
      a_valid = 1'b0;
      #1 reset_n = 1'b1;
      for (int i = 0; i <= 12; i++) begin
         step();
         chk($sformatf("resweep%0d wr_addr", i), 64'(wr_addr), 64'(i));
         chk($sformatf("resweep%0d wr_en", i), 64'(wr_en), 64'd1);
      end
      #2 reset_n = 1'b0;
      #1;
      chk_zero("sweepreset");
      #1 reset_n = 1'b1;
      step();
      chk("restart wr_en", 64'(wr_en), 64'd1);
      chk("restart wr_addr", 64'(wr_addr), 64'd0);
      chk("restart init_done", 64'(init_done), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
